// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Shared definitions for the E-stage multiply/divide unit:
//                operation encoding, default latencies and op-class helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

    // E-stage operation encoding
    localparam logic [2:0] c_OP_NONE  = 3'd0;
    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;

    // Default occupancy of the shared resource, in cycles
    localparam int c_MULT_LAT_DEF = 5;
    localparam int c_DIV_LAT_DEF  = 10;

    // True for the operations that occupy the unit for several cycles
    function automatic logic md_is_multi(input logic [2:0] op);
        return (op == c_OP_MULT) || (op == c_OP_MULTU) ||
               (op == c_OP_DIV)  || (op == c_OP_DIVU);
    endfunction

    // True for the divide operations (long latency)
    function automatic logic md_is_div(input logic [2:0] op);
        return (op == c_OP_DIV) || (op == c_OP_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_calc.sv
`default_nettype none
// ============================================================================
//  Module      : md_calc
//  Description : Combinational multiply/divide datapath. Produces the 64-bit
//                HI/LO result for (op,a,b) and flags divide-by-zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_calc
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic        [31:0] w_b_safe;
    logic        [31:0] w_a_mag;
    logic        [31:0] w_b_mag;
    logic        [31:0] w_qu;
    logic        [31:0] w_ru;
    logic        [31:0] w_qm;
    logic        [31:0] w_rm;
    logic        [31:0] w_qs;
    logic        [31:0] w_rs;

    assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // A zero divisor is replaced by 1 so the dividers never see x; the
    // result is discarded anyway because div0 suppresses the commit.
    assign w_b_safe = (b == 32'd0) ? 32'd1 : b;

    // Unsigned divide
    assign w_qu = a / w_b_safe;
    assign w_ru = a % w_b_safe;

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder takes the dividend's sign. 0x80000000 / -1 falls out as
    // quotient 0x80000000, remainder 0 with no special case.
    assign w_a_mag = a[31]        ? (~a + 32'd1)        : a;
    assign w_b_mag = w_b_safe[31] ? (~w_b_safe + 32'd1) : w_b_safe;
    assign w_qm    = w_a_mag / w_b_mag;
    assign w_rm    = w_a_mag % w_b_mag;
    assign w_qs    = (a[31] ^ w_b_safe[31]) ? (~w_qm + 32'd1) : w_qm;
    assign w_rs    = a[31] ? (~w_rm + 32'd1) : w_rm;

    // Select the result for the requested operation
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        div0   = 1'b0;
        case (op)
            c_OP_MULT: begin
                res_hi = w_prod_s[63:32];
                res_lo = w_prod_s[31:0];
            end
            c_OP_MULTU: begin
                res_hi = w_prod_u[63:32];
                res_lo = w_prod_u[31:0];
            end
            c_OP_DIV: begin
                res_hi = w_rs;
                res_lo = w_qs;
                div0   = (b == 32'd0);
            end
            c_OP_DIVU: begin
                res_hi = w_ru;
                res_lo = w_qu;
                div0   = (b == 32'd0);
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/md_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : md_ctrl
//  Description : Sequencer for the shared E-stage multiply/divide unit. Issues
//                one operation when idle, models its occupancy with a latency
//                counter, commits to HI/LO on completion and requests a
//                pipeline stall when D needs the unit while it is occupied.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_LAT = c_MULT_LAT_DEF,
    parameter int DIV_LAT  = c_DIV_LAT_DEF
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall
);

    localparam int c_MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_MULT = c_CNT_W'(MULT_LAT);
    localparam logic [c_CNT_W-1:0] c_CNT_DIV  = c_CNT_W'(DIV_LAT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;

    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;
    logic               r_pend_div0;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;
    logic               w_div0;
    logic               w_commit;

    md_calc u_calc (
        .op     (op),
        .a      (a),
        .b      (b),
        .res_hi (w_res_hi),
        .res_lo (w_res_lo),
        .div0   (w_div0)
    );

    // The unit is RUN whenever the counter is nonzero; issue only from IDLE,
    // so a second issue can never restart an operation in flight.
    assign busy     = (r_cnt != c_CNT_ZERO);
    assign start    = md_is_multi(op) && !busy;
    assign stall    = md_use && (start || busy);
    assign w_commit = (r_cnt == c_CNT_ONE);
    assign hi       = r_hi;
    assign lo       = r_lo;

    // Latency counter and capture of the pending result at issue
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= c_CNT_ZERO;
            r_pend_hi   <= 32'd0;
            r_pend_lo   <= 32'd0;
            r_pend_div0 <= 1'b0;
        end else if (start) begin
            r_cnt       <= md_is_div(op) ? c_CNT_DIV : c_CNT_MULT;
            r_pend_hi   <= w_res_hi;
            r_pend_lo   <= w_res_lo;
            r_pend_div0 <= w_div0;
        end else if (busy) begin
            r_cnt <= r_cnt - c_CNT_ONE;
        end
    end

    // Architectural HI/LO: commit on the 1->0 counter edge, or direct moves
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_commit) begin
            if (!r_pend_div0) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end else if (!busy && (op == c_OP_MTHI)) begin
            r_hi <= a;
        end else if (!busy && (op == c_OP_MTLO)) begin
            r_lo <= a;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_ctrl
//  Description : Self-checking bench for md_ctrl: directed scenarios plus
//                randomized traffic against a cycle-numbered reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_md_ctrl;
    import md_pkg::*;

    localparam int LM = 5;
    localparam int LD = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;

    always #5 clk = ~clk;

    md_ctrl #(.MULT_LAT(LM), .DIV_LAT(LD)) dut (
        .clk    (clk),
        .reset  (reset),
        .op     (op),
        .a      (a),
        .b      (b),
        .md_use (md_use),
        .start  (start),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .stall  (stall)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: an operation issued in cycle t_issue is busy during
    // cycles t_issue+1 .. t_issue+t_lat and its result is visible afterwards.
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    bit          m_pvalid;
    int          cyc;
    int          t_issue;
    int          t_lat;

    function automatic bit m_busy();
        return (cyc > t_issue) && (cyc <= t_issue + t_lat);
    endfunction

    function automatic bit m_is_multi(input logic [2:0] o);
        return (o == c_OP_MULT) || (o == c_OP_MULTU) || (o == c_OP_DIV) || (o == c_OP_DIVU);
    endfunction

    task automatic m_clear();
        m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pvalid = 0;
        t_issue = -1000; t_lat = 0;
    endtask

    task automatic m_result(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                            output logic [31:0] rh, output logic [31:0] rl, output bit ok);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        sa = $signed(av); sb = $signed(bv);
        ua = {32'd0, av}; ub = {32'd0, bv};
        rh = 0; rl = 0; ok = 1;
        case (o)
            c_OP_MULT:  begin sp = sa * sb; rh = sp[63:32]; rl = sp[31:0]; end
            c_OP_MULTU: begin up = ua * ub; rh = up[63:32]; rl = up[31:0]; end
            c_OP_DIV: begin
                if (bv == 0) ok = 0;
                else begin sq = sa / sb; sr = sa % sb; rl = sq[31:0]; rh = sr[31:0]; end
            end
            c_OP_DIVU: begin
                if (bv == 0) ok = 0;
                else begin up = ua / ub; rl = up[31:0]; up = ua % ub; rh = up[31:0]; end
            end
            default: ok = 0;
        endcase
    endtask

    // One clock cycle: drive, check against model, advance model at the edge
    task automatic step(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic mu, input string tag);
        bit eb, es;
        op = o; a = av; b = bv; md_use = mu;
        #1;
        eb = m_busy();
        es = !eb && m_is_multi(o);
        chk({tag, ".start"}, {63'd0, start}, {63'd0, es});
        chk({tag, ".busy"},  {63'd0, busy},  {63'd0, eb});
        chk({tag, ".stall"}, {63'd0, stall}, {63'd0, mu && (es || eb)});
        chk({tag, ".hi"},    {32'd0, hi},    {32'd0, m_hi});
        chk({tag, ".lo"},    {32'd0, lo},    {32'd0, m_lo});
        @(posedge clk);
        if (cyc == t_issue + t_lat && m_pvalid) begin
            m_hi = m_phi; m_lo = m_plo;
        end
        if (es) begin
            m_result(o, av, bv, m_phi, m_plo, m_pvalid);
            t_issue = cyc;
            t_lat   = (o == c_OP_DIV || o == c_OP_DIVU) ? LD : LM;
        end else if (!eb && o == c_OP_MTHI) begin
            m_hi = av;
        end else if (!eb && o == c_OP_MTLO) begin
            m_lo = av;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic mu, input string tag);
        for (int i = 0; i < n; i++) step(c_OP_NONE, 32'd0, 32'd0, mu, tag);
    endtask

    function automatic logic [31:0] rnd_operand();
        logic [31:0] corners [5];
        corners = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom();
    endfunction

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        reset = 1'b0; op = c_OP_NONE; a = 0; b = 0; md_use = 0;
        cyc = 0;
        m_clear();
        @(negedge clk); @(negedge clk);
        chk("rst.busy", {63'd0, busy}, 64'd0);
        chk("rst.hi",   {32'd0, hi},   64'd0);
        chk("rst.lo",   {32'd0, lo},   64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Signed multiply, negative operand
        step(c_OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult");
        idle(LM, 1'b0, "mult.run");
        chk("mult.res_hi", {32'd0, hi}, {32'd0, 32'hFFFF_FFFF});
        chk("mult.res_lo", {32'd0, lo}, {32'd0, 32'hFFFF_FFFA});

        // Unsigned multiply
        step(c_OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, "multu");
        idle(LM, 1'b0, "multu.run");
        chk("multu.res_hi", {32'd0, hi}, {32'd0, 32'h0000_0001});
        chk("multu.res_lo", {32'd0, lo}, {32'd0, 32'hFFFF_FFFE});

        // Signed divide, negative dividend
        step(c_OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, "div");
        idle(LD, 1'b0, "div.run");
        chk("div.res_hi", {32'd0, hi}, {32'd0, 32'hFFFF_FFFF});
        chk("div.res_lo", {32'd0, lo}, {32'd0, 32'hFFFF_FFFD});

        // Divide by zero leaves HI/LO untouched
        step(c_OP_DIVU, 32'd7, 32'd0, 1'b0, "div0");
        idle(LD, 1'b0, "div0.run");
        chk("div0.res_hi", {32'd0, hi}, {32'd0, 32'hFFFF_FFFF});
        chk("div0.res_lo", {32'd0, lo}, {32'd0, 32'hFFFF_FFFD});

        // Stall while busy, MTHI right after busy falls
        step(c_OP_MULT, 32'd3, 32'd4, 1'b1, "stall");
        idle(LM, 1'b1, "stall.run");
        step(c_OP_MTHI, 32'h1234, 32'd0, 1'b1, "mthi");
        step(c_OP_NONE, 32'd0, 32'd0, 1'b0, "mthi.after");
        chk("mthi.hi", {32'd0, hi}, {32'd0, 32'h0000_1234});

        // Signed overflow case
        step(c_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "ovf");
        idle(LD, 1'b0, "ovf.run");
        chk("ovf.hi", {32'd0, hi}, 64'd0);
        chk("ovf.lo", {32'd0, lo}, {32'd0, 32'h8000_0000});

        // A MULT arriving while a DIV is in flight is ignored
        step(c_OP_DIV, 32'd100, 32'd7, 1'b0, "busyiss");
        step(c_OP_MULT, 32'd5, 32'd5, 1'b0, "busyiss.mult");
        step(c_OP_MTLO, 32'hDEAD, 32'd0, 1'b0, "busyiss.mtlo");
        idle(LD - 1, 1'b0, "busyiss.run");
        chk("busyiss.hi", {32'd0, hi}, 64'd2);
        chk("busyiss.lo", {32'd0, lo}, 64'd14);

        // Reset in the middle of a divide
        step(c_OP_MTHI, 32'hAAAA, 32'd0, 1'b0, "mrst.pre");
        step(c_OP_MTLO, 32'h5555, 32'd0, 1'b0, "mrst.pre");
        step(c_OP_DIV, 32'd1000, 32'd3, 1'b0, "mrst.div");
        idle(2, 1'b0, "mrst.run");
        op = c_OP_NONE;
        reset = 1'b0;
        #1;
        m_clear();
        chk("mrst.busy", {63'd0, busy}, 64'd0);
        chk("mrst.hi",   {32'd0, hi},   64'd0);
        chk("mrst.lo",   {32'd0, lo},   64'd0);
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        idle(LD + 2, 1'b0, "mrst.after");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            ra = rnd_operand();
            rb = ($urandom_range(0, 9) == 0) ? 32'd0 : rnd_operand();
            if (m_busy() && $urandom_range(0, 7) != 0) ro = c_OP_NONE;
            else ro = 3'($urandom_range(0, 6));
            step(ro, ra, rb, 1'($urandom_range(0, 1)), "rnd");
        end
        idle(LD + 1, 1'b0, "drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
